// File: rtl/pipe_reg_elastic_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
package pipe_reg_elastic_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  // Payload value held by any empty entry; replicated to DATA_W at use.
  localparam logic PAYLOAD_RST_BIT = 1'b0;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_slot.sv
// One elastic slot: a main entry, plus a skid entry when PIPE_REG_SKID_EN is defined.
module pipe_slot
  import pipe_reg_elastic_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        count_next
);

  localparam logic [DATA_W-1:0] PAYLOAD_RST = {DATA_W{PAYLOAD_RST_BIT}};

  logic              kill;
  logic              main_valid, main_valid_nx;
  logic [DATA_W-1:0] main_data, main_data_nx;

  assign kill     = rst | flush;
  assign dn_valid = main_valid;
  assign dn_data  = main_data;

`ifdef PIPE_REG_SKID_EN
  logic              skid_valid, skid_valid_nx;
  logic [DATA_W-1:0] skid_data, skid_data_nx;
  logic              up_fire, dn_fire;

  // Ready comes straight from a flop, so no path from dn_ready to up_ready.
  assign up_ready = ~skid_valid;
  assign up_fire  = up_valid & ~skid_valid;
  assign dn_fire  = main_valid & dn_ready;

  always_comb begin
    main_valid_nx = main_valid;
    main_data_nx  = main_data;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    if (kill) begin
      main_valid_nx = 1'b0;
      main_data_nx  = PAYLOAD_RST;
      skid_valid_nx = 1'b0;
      skid_data_nx  = PAYLOAD_RST;
    end else if (dn_fire && skid_valid) begin
      main_valid_nx = 1'b1;
      main_data_nx  = skid_data;
      skid_valid_nx = 1'b0;
      skid_data_nx  = PAYLOAD_RST;
    end else if (dn_fire) begin
      main_valid_nx = up_fire;
      main_data_nx  = up_fire ? up_data : PAYLOAD_RST;
    end else if (up_fire && main_valid) begin
      skid_valid_nx = 1'b1;
      skid_data_nx  = up_data;
    end else if (up_fire) begin
      main_valid_nx = 1'b1;
      main_data_nx  = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= PAYLOAD_RST;
      skid_valid <= 1'b0;
      skid_data  <= PAYLOAD_RST;
    end else begin
      main_valid <= main_valid_nx;
      main_data  <= main_data_nx;
      skid_valid <= skid_valid_nx;
      skid_data  <= skid_data_nx;
    end
  end

  assign count_next = {1'b0, main_valid_nx} + {1'b0, skid_valid_nx};
`else
  assign up_ready = ~main_valid | dn_ready;

  always_comb begin
    main_valid_nx = main_valid;
    main_data_nx  = main_data;
    if (kill) begin
      main_valid_nx = 1'b0;
      main_data_nx  = PAYLOAD_RST;
    end else if (up_valid && up_ready) begin
      main_valid_nx = 1'b1;
      main_data_nx  = up_data;
    end else if (main_valid && dn_ready) begin
      main_valid_nx = 1'b0;
      main_data_nx  = PAYLOAD_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= PAYLOAD_RST;
    end else begin
      main_valid <= main_valid_nx;
      main_data  <= main_data_nx;
    end
  end

  assign count_next = {1'b0, main_valid_nx};
`endif

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH chained pipe_slot instances with registered occupancy.
// Build option: define PIPE_REG_SKID_EN to give every slot a skid entry.
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [DATA_W-1:0]            inData,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [DATA_W-1:0]            outData,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipe_reg_elastic: DEPTH out of range");
  end

  logic              chain_valid [0:DEPTH];
  logic              chain_ready [0:DEPTH];
  logic [DATA_W-1:0] chain_data  [0:DEPTH];
  logic [1:0]        slot_count  [0:DEPTH-1];
  logic [OCC_W-1:0]  occ_sum;

  assign chain_valid[0]     = inValid;
  assign chain_data[0]      = inData;
  assign chain_ready[DEPTH] = outReady;
  assign inReady            = chain_ready[0];
  assign outValid           = chain_valid[DEPTH];
  assign outData            = chain_data[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (chain_valid[k]),
      .up_ready   (chain_ready[k]),
      .up_data    (chain_data[k]),
      .dn_valid   (chain_valid[k+1]),
      .dn_ready   (chain_ready[k+1]),
      .dn_data    (chain_data[k+1]),
      .count_next (slot_count[k])
    );
  end

  // Summing next-state valid bits keeps the registered count in step with the slots.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_sum = occ_sum + OCC_W'(slot_count[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_sum;
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic (DEPTH=2 and DEPTH=1 instances), skid-aware via PIPE_REG_SKID_EN.
module tb_pipe_reg_elastic;

`ifdef PIPE_REG_SKID_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [2:0]  occ;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0] in_data1, out_data1;
  logic [1:0]  occ1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.DATA_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(in_valid), .inReady(in_ready), .inData(in_data),
    .outValid(out_valid), .outReady(out_ready), .outData(out_data),
    .occupancy(occ)
  );

  pipe_reg_elastic #(.DATA_W(16), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(in_valid1), .inReady(in_ready1), .inData(in_data1),
    .outValid(out_valid1), .outReady(out_ready1), .outData(out_data1),
    .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, a, c;
    int q[$];
    int exp_d;
    logic [15:0] seq, held;
    logic stall_prev, in_hold, in_fire, out_fire;

    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
    in_valid1 = 1'b1; in_data1 = 16'hDEAD; out_ready1 = 1'b1;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ1", occ1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nothing_emerges", out_valid, 0);
    end

    // Streaming 1..8 back to back
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_data  = 16'(i + 1);
      #1;
      if (i < 8) chk("stream_in_ready", in_ready, 1);
      tick();
      a = (i + 1 < 8) ? i + 1 : 8;
      c = (i - 1 < 0) ? 0 : ((i - 1 > 8) ? 8 : i - 1);
      chk("stream_out_valid", out_valid, (i >= 1 && i <= 8));
      chk("stream_out_data", out_data, (i >= 1 && i <= 8) ? i : 0);
      chk("stream_occ", occ, a - c);
    end

    // Back-pressure fill
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h10 + acc);
      #1;
      chk("bp_in_ready", in_ready, (i < CAP));
      tick();
      if (i < CAP) acc++;
      chk("bp_out_valid", out_valid, (i >= 1));
      chk("bp_out_data", out_data, (i >= 1) ? 16'h10 : 16'h0);
    end
    chk("bp_occ_full", occ, CAP);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < CAP; j++) begin
      #1;
      chk("bp_release_valid", out_valid, 1);
      chk("bp_release_data", out_data, 16'h10 + j);
      tick();
    end
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_drained_occ", occ, 0);

    // Flush of a full pipe with a simultaneous input
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h20 + i);
      tick();
    end
    chk("fl_occ_full", occ, CAP);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h55; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_occ", occ, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_data", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_0x55", out_valid, 0);
    end

    // Simultaneous in/out at full, DEPTH=1
    in_valid1 = 1'b1; in_data1 = 16'hA; out_ready1 = 1'b0;
    tick();
    chk("sim_hold_data", out_data1, 16'hA);
    chk("sim_hold_occ", occ1, 1);
    in_data1 = 16'hB; out_ready1 = 1'b1;
    #1;
    chk("sim_in_ready", in_ready1, 1);
    chk("sim_out_data_a", out_data1, 16'hA);
    tick();
    in_valid1 = 1'b0;
    #1;
    chk("sim_out_data_b", out_data1, 16'hB);
    chk("sim_out_valid", out_valid1, 1);
    chk("sim_occ", occ1, 1);
    tick();
    chk("sim_empty_valid", out_valid1, 0);
    chk("sim_empty_occ", occ1, 0);

    // Random valid/ready with scoreboard, DEPTH=2
    seq = 16'h100; stall_prev = 1'b0; in_hold = 1'b0; held = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!in_hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = seq;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        chk("rnd_stall_valid", out_valid, 1);
        chk("rnd_stall_data", out_data, held);
      end
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      if (out_fire) begin
        if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
        else begin
          exp_d = q.pop_front();
          chk("rnd_order", out_data, exp_d);
        end
      end
      stall_prev = out_valid & ~out_ready;
      held = out_data;
      if (in_fire) begin
        q.push_back(int'(in_data));
        seq = seq + 16'd1;
      end
      in_hold = in_valid & ~in_fire;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_drain_spurious", out_valid, 0);
        else begin
          exp_d = q.pop_front();
          chk("rnd_drain_order", out_data, exp_d);
        end
      end
      tick();
    end
    chk("rnd_left_in_sb", q.size(), 0);
    chk("rnd_final_occ", occ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
